// File: rtl/operand_fetch_pkg.sv
// Shared constants, encodings and helpers for the operand-fetch stage.
package operand_fetch_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READ_A = 2'b01,
    ST_READ_B = 2'b10,
    ST_ISSUE  = 2'b11
  } state_e;

  // Operand-selection fields captured at the accept edge.
  typedef struct packed {
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    shift_e        shift;
    logic          asel;
    logic          bsel;
    logic [4:0]    imm5;
  } instr_t;

  function automatic logic [DW-1:0] sext16(input logic [4:0] imm);
    return {{(DW-5){imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// 8x16 register file: one combinational write-first read port, one write port.
module operand_fetch_regfile
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle write to the read index wins.
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads Rn then Rm, applies shift/selects, hands Ain/Bin to the ALU.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [AW-1:0] rd,
  input  logic [1:0]    shift,
  input  logic [1:0]    aluop,
  input  logic          asel,
  input  logic          bsel,
  input  logic [4:0]    imm5,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [1:0]    ALUop,
  output logic [AW-1:0] rd_out,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  state_e        state, state_n;
  instr_t        instr_q, instr_n;
  logic [DW-1:0] ain_n, bin_n;
  logic [1:0]    aluop_n;
  logic [AW-1:0] rd_n;
  logic          out_valid_n;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] shifted;

  operand_fetch_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign in_ready = (state == ST_IDLE);
  assign raddr    = (state == ST_READ_A) ? instr_q.rn : instr_q.rm;

  // Rm barrel shift; never applied to the immediate.
  always_comb begin
    shifted = rdata;
    case (instr_q.shift)
      SH_LSL:  shifted = {rdata[DW-2:0], 1'b0};
      SH_LSR:  shifted = {1'b0, rdata[DW-1:1]};
      SH_ASR:  shifted = {rdata[DW-1], rdata[DW-1:1]};
      default: shifted = rdata;
    endcase
  end

  always_comb begin
    state_n     = state;
    instr_n     = instr_q;
    ain_n       = Ain;
    bin_n       = Bin;
    aluop_n     = ALUop;
    rd_n        = rd_out;
    out_valid_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          instr_n.rn    = rn;
          instr_n.rm    = rm;
          instr_n.shift = shift_e'(shift);
          instr_n.asel  = asel;
          instr_n.bsel  = bsel;
          instr_n.imm5  = imm5;
          aluop_n       = aluop;
          rd_n          = rd;
          state_n       = ST_READ_A;
        end
      end
      ST_READ_A: begin
        ain_n   = instr_q.asel ? '0 : rdata;
        state_n = ST_READ_B;
      end
      ST_READ_B: begin
        bin_n       = instr_q.bsel ? sext16(instr_q.imm5) : shifted;
        state_n     = ST_ISSUE;
        out_valid_n = 1'b1;
      end
      ST_ISSUE: begin
        if (out_ready) state_n = ST_IDLE;
        else           out_valid_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      instr_q   <= '0;
      Ain       <= '0;
      Bin       <= '0;
      ALUop     <= '0;
      rd_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      instr_q   <= instr_n;
      Ain       <= ain_n;
      Bin       <= bin_n;
      ALUop     <= aluop_n;
      rd_out    <= rd_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, corner sequences, random vs model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  shift, aluop;
  logic        asel, bsel;
  logic [4:0]  imm5;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;
  logic [2:0]  rd_out;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [8];

  operand_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rn        (rn),
    .rm        (rm),
    .rd        (rd),
    .shift     (shift),
    .aluop     (aluop),
    .asel      (asel),
    .bsel      (bsel),
    .imm5      (imm5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .rd_out    (rd_out),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  w1a;
    logic [15:0] w1d;
    logic [2:0]  w2a;
    logic [15:0] w2d;
    logic [2:0]  rn, rm, rd;
    logic [1:0]  sh, op;
    logic        asl, bsl;
    logic [4:0]  im;
    int          hold;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model register file follows the same edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0;
    end else if (wb_en) begin
      model[wb_addr] = wb_data;
    end
    #1;
  endtask

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] s);
    case (s)
      2'd1:    return 16'(x << 1);
      2'd2:    return x >> 1;
      2'd3:    return 16'($signed(x) >>> 1);
      default: return x;
    endcase
  endfunction

  function automatic logic [15:0] rd_model(input logic [2:0] idx);
    return (wb_en && wb_addr == idx) ? wb_data : model[idx];
  endfunction

  task automatic drive_wb(input bit rnd);
    wb_en   = rnd ? 1'($urandom) : 1'b0;
    wb_addr = 3'($urandom);
    wb_data = 16'($urandom);
  endtask

  task automatic junk();
    in_valid  = 1'($urandom);
    rn        = 3'($urandom);
    rm        = 3'($urandom);
    rd        = 3'($urandom);
    shift     = 2'($urandom);
    aluop     = 2'($urandom);
    asel      = 1'($urandom);
    bsel      = 1'($urandom);
    imm5      = 5'($urandom);
    out_ready = 1'($urandom);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic do_txn(input logic [2:0] rn_i, input logic [2:0] rm_i, input logic [2:0] rd_i,
                        input logic [1:0] sh_i, input logic [1:0] op_i,
                        input logic as_i, input logic bs_i, input logic [4:0] im_i,
                        input bit rnd, input int hold,
                        input bit wa_en, input logic [2:0] wa_addr, input logic [15:0] wa_data,
                        input bit use_tab, input logic [15:0] tab_a, input logic [15:0] tab_b);
    logic [15:0] ea, eb;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; rn = rn_i; rm = rm_i; rd = rd_i; shift = sh_i; aluop = op_i;
    asel = as_i; bsel = bs_i; imm5 = im_i; out_ready = 1'($urandom);
    drive_wb(rnd);
    step();
    // READ_A cycle
    junk();
    drive_wb(rnd);
    if (wa_en) begin wb_en = 1'b1; wb_addr = wa_addr; wb_data = wa_data; end
    check("reada_in_ready", 32'(in_ready), 32'd0);
    check("reada_out_valid", 32'(out_valid), 32'd0);
    ea = as_i ? 16'h0 : rd_model(rn_i);
    step();
    // READ_B cycle; a late write to the A index must not disturb Ain
    junk();
    drive_wb(rnd);
    if (wa_en) begin wb_en = 1'b1; wb_addr = wa_addr; wb_data = 16'hDEAD; end
    check("readb_out_valid", 32'(out_valid), 32'd0);
    eb = bs_i ? 16'($signed(im_i)) : shf(rd_model(rm_i), sh_i);
    step();
    if (use_tab) begin ea = tab_a; eb = tab_b; end
    check("issue_out_valid", 32'(out_valid), 32'd1);
    check("issue_in_ready", 32'(in_ready), 32'd0);
    check("issue_ain", 32'(Ain), 32'(ea));
    check("issue_bin", 32'(Bin), 32'(eb));
    check("issue_aluop", 32'(ALUop), 32'(op_i));
    check("issue_rd_out", 32'(rd_out), 32'(rd_i));
    for (int h = 0; h < hold; h++) begin
      junk();
      out_ready = 1'b0;
      drive_wb(rnd);
      step();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_ain", 32'(Ain), 32'(ea));
      check("hold_bin", 32'(Bin), 32'(eb));
      check("hold_aluop", 32'(ALUop), 32'(op_i));
      check("hold_rd_out", 32'(rd_out), 32'(rd_i));
    end
    junk();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_wb(rnd);
    step();
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    wb_en    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd1, 16'h0005, 3'd2, 16'h0003, 3'd1, 3'd2, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  0, 16'h0005, 16'h0003};
    vecs[1] = '{3'd2, 16'h8001, 3'd2, 16'h8001, 3'd1, 3'd2, 3'd5, 2'd1, 2'd1, 1'b0, 1'b0, 5'd0,  0, 16'h0005, 16'h0002};
    vecs[2] = '{3'd2, 16'h8001, 3'd2, 16'h8001, 3'd1, 3'd2, 3'd6, 2'd2, 2'd2, 1'b0, 1'b0, 5'd0,  1, 16'h0005, 16'h4000};
    vecs[3] = '{3'd2, 16'h8001, 3'd2, 16'h8001, 3'd1, 3'd2, 3'd7, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0,  0, 16'h0005, 16'hC000};
    vecs[4] = '{3'd7, 16'hAAAA, 3'd6, 16'h5555, 3'd7, 3'd6, 3'd0, 2'd1, 2'd3, 1'b1, 1'b1, 5'b10110, 5, 16'h0000, 16'hFFF6};
    vecs[5] = '{3'd7, 16'hAAAA, 3'd6, 16'h5555, 3'd7, 3'd6, 3'd2, 2'd3, 2'd0, 1'b0, 1'b1, 5'b01111, 0, 16'hAAAA, 16'h000F};
    vecs[6] = '{3'd7, 16'hAAAA, 3'd6, 16'h5555, 3'd6, 3'd7, 3'd3, 2'd2, 2'd1, 1'b0, 1'b0, 5'd0,  2, 16'h5555, 16'h5555};
    vecs[7] = '{3'd7, 16'hAAAA, 3'd6, 16'h5555, 3'd6, 3'd7, 3'd1, 2'd3, 2'd2, 1'b0, 1'b0, 5'd0,  0, 16'h5555, 16'hD555};

    for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rn = '0; rm = '0; rd = '0; shift = '0; aluop = '0; asel = 1'b0; bsel = 1'b0; imm5 = '0;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'hFFFF;
    step();
    step();
    reset = 1'b0; wb_en = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ain", 32'(Ain), 32'd0);
    check("rst_bin", 32'(Bin), 32'd0);
    check("rst_aluop", 32'(ALUop), 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      wr(vecs[v].w1a, vecs[v].w1d);
      wr(vecs[v].w2a, vecs[v].w2d);
      do_txn(vecs[v].rn, vecs[v].rm, vecs[v].rd, vecs[v].sh, vecs[v].op,
             vecs[v].asl, vecs[v].bsl, vecs[v].im, 1'b0, vecs[v].hold,
             1'b0, 3'd0, 16'h0, 1'b1, vecs[v].ea, vecs[v].eb);
    end

    // Write-first bypass in READ_A; later write to R1 in READ_B must not leak
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h8001);
    do_txn(3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1,
           1'b1, 3'd1, 16'h1234, 1'b1, 16'h1234, 16'h8001);

    // Reset in the READ_B cycle drops the instruction and clears registers
    wr(3'd1, 16'h0005);
    in_valid = 1'b1; rn = 3'd1; rm = 3'd1; rd = 3'd2; shift = 2'd0; aluop = 2'd1;
    asel = 1'b0; bsel = 1'b0; imm5 = 5'd0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    step();
    reset = 1'b0; wb_en = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_ain", 32'(Ain), 32'd0);
    check("midrst_bin", 32'(Bin), 32'd0);
    step();
    check("midrst_idle_out_valid", 32'(out_valid), 32'd0);
    do_txn(3'd1, 3'd3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 0,
           1'b0, 3'd0, 16'h0, 1'b1, 16'h0000, 16'h0000);

    // Randomized transactions with concurrent writebacks against the model
    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        drive_wb(1'b1);
        step();
      end
      do_txn(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 5'($urandom), 1'b1, $urandom_range(0, 3),
             1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
